// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_pkg;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
// slave is the loader side, master is the producer/memory side.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = AW
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    inst_t             mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid fires
// combinationally with the fourth byte so the caller can register it.
module byte_packer
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] byte_data,
    output logic       word_valid,
    output inst_t      word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid = byte_en && (cnt_q == 2'd3);
    assign word       = {shift_q, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory from word 0 and stalls fetch
// meanwhile. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW:0]     word_count,
    imem_loader_if.slave    bus,
    output logic            hold,
    output logic            done,
    output logic            err
);

    loader_state_e state_q, state_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    inst_t         mem_wdata_q, mem_wdata_d;
    logic          done_q, done_d;
    logic          in_ready;
    logic          load_byte;
    logic          pack_clear;
    logic          word_valid;
    inst_t         word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        in_ready = (state_q == S_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = in_ready || (state_q == S_CHECK);
`endif
    end

    assign load_byte = bus.in_valid && in_ready && (state_q == S_LOAD);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (pack_clear),
        .byte_en    (load_byte),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        waddr_d     = waddr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pack_clear  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = (word_count == '0) ? (AW + 1)'(DEPTH) : word_count;
                    waddr_d     = '0;
                    pack_clear  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = '0;
                    err_d       = 1'b0;
`endif
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (load_byte) csum_d = csum_q ^ bus.in_data;
`endif
                // waddr advances on the same edge the old value is captured for the write
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = waddr_q;
                    mem_wdata_d = word;
                    waddr_d     = waddr_q + AW'(1);
                    remaining_d = remaining_q - (AW + 1)'(1);
                    if (remaining_q == (AW + 1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (bus.in_valid) begin
                    err_d   = (bus.in_data != csum_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            waddr_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            waddr_q     <= waddr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign hold          = (state_q != S_IDLE);
    assign done          = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum cases build only with
// IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [AW:0] word_count;
    logic        hold, done, err;

    imem_loader_if bus ();

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .hold       (hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [AW-1:0] wa[$];
    inst_t         wd[$];
    int unsigned   hold_drops;
    logic          watch_hold;
    logic [7:0]    xacc;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
        if (watch_hold && !hold) hold_drops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned waited;
        waited      = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 100) begin
            tick(1);
            waited++;
        end
        if (waited == 100) check("in_ready_wait", bus.in_ready, 1);
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input inst_t w, input int unsigned gap);
        for (int unsigned k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = w[31 - 8*k -: 8];
            send_byte(b);
            xacc ^= b;
            tick(gap);
        end
    endtask

    task automatic do_start(input logic [AW:0] n);
        start      = 1'b1;
        word_count = n;
        tick(1);
        start      = 1'b0;
        xacc       = '0;
        wa.delete();
        wd.delete();
    endtask

    task automatic end_load(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("check_in_ready", bus.in_ready, 1);
        check("done_before_csum", done, 0);
        send_byte(csum);
`endif
        check("done_pulse", done, 1);
        check("hold_in_done", hold, 1);
        tick(1);
        check("done_clear", done, 0);
        check("hold_idle", hold, 0);
        check("ready_idle", bus.in_ready, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_hold"}, hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    inst_t t2_words [3] = '{32'h13579BDF, 32'h2468ACE0, 32'hDEADBEEF};

    initial begin
        int unsigned zero_cnt, addr_errs, data_errs;

        rst = 1'b1; start = 1'b0; word_count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        watch_hold = 1'b0; hold_drops = 0; xacc = '0;
        #2 rst = 1'b0;
        tick(2);
        check_reset_vals("rst");
        rst = 1'b1;
        tick(1);

        // single word, back-to-back bytes
        do_start(1);
        check("t1_ready_after_start", bus.in_ready, 1);
        check("t1_hold_after_start", hold, 1);
        send_word(32'h8C220004, 0);
        check("t1_mem_we", bus.mem_we, 1);
        check("t1_mem_addr", bus.mem_addr, 0);
        check("t1_mem_wdata", bus.mem_wdata, 32'h8C220004);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_ready_after_last", bus.in_ready, 1);
`else
        check("t1_ready_after_last", bus.in_ready, 0);
`endif
        end_load(xacc);
        check("t1_writes", wa.size(), 1);
        check("t1_err", err, 0);

        // three words with gaps
        do_start(3);
        watch_hold = 1'b1;
        for (int i = 0; i < 3; i++) send_word(t2_words[i], (i + 1) % 3);
        watch_hold = 1'b0;
        end_load(xacc);
        check("t2_writes", wa.size(), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            check($sformatf("t2_addr%0d", i), wa[i], i);
            check($sformatf("t2_data%0d", i), wd[i], t2_words[i]);
        end
        check("t2_hold_drops", hold_drops, 0);

        // word_count 0 loads the full depth
        do_start(0);
        for (int unsigned i = 0; i < DEPTH; i++) send_word(32'hC0DE0000 | i, 0);
        end_load(xacc);
        check("t3_writes", wa.size(), DEPTH);
        zero_cnt = 0; addr_errs = 0; data_errs = 0;
        for (int unsigned i = 0; i < wa.size(); i++) begin
            if (wa[i] == '0) zero_cnt++;
            if (wa[i] != AW'(i)) addr_errs++;
            if (wd[i] != (32'hC0DE0000 | i)) data_errs++;
        end
        check("t3_addr0_writes", zero_cnt, 1);
        check("t3_addr_seq_errs", addr_errs, 0);
        check("t3_data_errs", data_errs, 0);
        if (wa.size() == DEPTH) check("t3_last_addr", wa[DEPTH-1], DEPTH - 1);

        // reset after two bytes of word 5
        do_start(8);
        for (int unsigned i = 0; i < 5; i++) send_word(32'hA0000000 + i, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        tick(3);
        check_reset_vals("t4");
        check("t4_writes", wa.size(), 5);
        rst = 1'b1;
        tick(1);
        do_start(1);
        send_word(32'h0BADF00D, 0);
        end_load(xacc);
        check("t4_restart_writes", wa.size(), 1);
        if (wa.size() > 0) begin
            check("t4_restart_addr", wa[0], 0);
            check("t4_restart_data", wd[0], 32'h0BADF00D);
        end

        // start during LOAD is ignored
        do_start(2);
        send_word(32'h11223344, 0);
        start = 1'b1; word_count = 3;
        tick(1);
        start = 1'b0;
        send_word(32'h55667788, 0);
        end_load(xacc);
        check("t5_writes", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t5_addr1", wa[1], 1);
            check("t5_data1", wd[1], 32'h55667788);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start(1);
        send_word(32'h01020304, 0);
        end_load(8'h04);
        check("t6_err_good", err, 0);
        do_start(1);
        send_word(32'h01020304, 0);
        end_load(8'h05);
        check("t6_err_bad", err, 1);
        tick(3);
        check("t6_err_sticky", err, 1);
        do_start(1);
        check("t6_err_cleared", err, 0);
        send_word(32'h01020304, 0);
        end_load(xacc);
        check("t6_err_after", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
